// File: rtl/dr_load_sequencer_if.sv
// Interface bundle for dr_load_sequencer.
// Request side: Start, Size, SignExt, Abort.
// Memory side: MemRead/AddrOffset out, MemData/MemValid in.
// Data Register side: DR_I, DR_E, DR_FunSel.
// Status: Busy, Done, Error.
// master = driver of the sequencer (requester + memory), slave = the sequencer.
interface dr_load_sequencer_if;
  logic       Start;
  logic [1:0] Size;
  logic       SignExt;
  logic       Abort;
  logic [7:0] MemData;
  logic       MemValid;
  logic       MemRead;
  logic [1:0] AddrOffset;
  logic [7:0] DR_I;
  logic       DR_E;
  logic [1:0] DR_FunSel;
  logic       Busy;
  logic       Done;
  logic       Error;

  modport master (
    output Start, Size, SignExt, Abort, MemData, MemValid,
    input  MemRead, AddrOffset, DR_I, DR_E, DR_FunSel, Busy, Done, Error
  );

  modport slave (
    input  Start, Size, SignExt, Abort, MemData, MemValid,
    output MemRead, AddrOffset, DR_I, DR_E, DR_FunSel, Busy, Done, Error
  );
endinterface

// File: rtl/dr_load_sequencer.sv
// Loads a 1..4 byte big-endian value from byte-wide memory into a 32-bit
// Data Register, one FETCH/WRITE pair per byte, then pulses Done.
// Ports:
//   Clock  - rising-edge clock
//   Reset  - synchronous active-high reset, highest priority
//   bus    - dr_load_sequencer_if.slave (request, memory, DR and status signals)
// Parameter TIMEOUT: FETCH cycles without MemValid tolerated before Error.
module dr_load_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Reset,
  dr_load_sequencer_if.slave bus
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    dr_i_q, dr_i_d;

  logic       mem_read;
  logic [1:0] addr_offset;
  logic       dr_e;
  logic [1:0] dr_funsel;
  logic       done;
  logic       error;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      sext_q     <= 1'b0;
      byte_cnt_q <= '0;
      tcnt_q     <= '0;
      dr_i_q     <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      byte_cnt_q <= byte_cnt_d;
      tcnt_q     <= tcnt_d;
      dr_i_q     <= dr_i_d;
    end
  end

  // Abort is checked first in every busy state so it beats MemValid,
  // timeout, the DR write and the Done pulse.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    sext_d      = sext_q;
    byte_cnt_d  = byte_cnt_q;
    tcnt_d      = tcnt_q;
    dr_i_d      = dr_i_q;
    mem_read    = 1'b0;
    addr_offset = '0;
    dr_e        = 1'b0;
    dr_funsel   = '0;
    done        = 1'b0;
    error       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          size_d     = bus.Size;
          sext_d     = bus.SignExt;
          byte_cnt_d = '0;
          tcnt_d     = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_read    = 1'b1;
        addr_offset = byte_cnt_q;
        if (bus.Abort) begin
          state_d = S_IDLE;
        end else if (bus.MemValid) begin
          dr_i_d  = bus.MemData;
          state_d = S_WRITE;
        end else if (tcnt_q == TW'(TIMEOUT)) begin
          error   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WRITE: begin
        if (bus.Abort) begin
          state_d = S_IDLE;
        end else begin
          dr_e = 1'b1;
          // First byte loads (zero/sign extended); later bytes shift in.
          dr_funsel = (byte_cnt_q == 2'd0) ? {1'b0, sext_q} : 2'b10;
          if (byte_cnt_q == size_q) begin
            state_d = S_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            tcnt_d     = '0;
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done    = ~bus.Abort;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.MemRead    = mem_read;
  assign bus.AddrOffset = addr_offset;
  assign bus.DR_I       = dr_i_q;
  assign bus.DR_E       = dr_e;
  assign bus.DR_FunSel  = dr_funsel;
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.Done       = done;
  assign bus.Error      = error;

endmodule

// File: tb/tb_dr_load_sequencer.sv
module tb_dr_load_sequencer;

  logic Clock;
  logic Reset;

  dr_load_sequencer_if bus ();

  dr_load_sequencer #(.TIMEOUT(15)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Memory responder: valid after mem_delay waiting FETCH cycles.
  logic [7:0] mem_b [4];
  int         mem_delay = 0;
  bit         mem_en = 1'b1;
  bit         force_valid = 1'b0;
  int         wait_cnt = 0;

  assign bus.MemData  = mem_b[bus.AddrOffset];
  assign bus.MemValid = force_valid | (mem_en & bus.MemRead & (wait_cnt >= mem_delay));

  always @(posedge Clock)
    wait_cnt <= (bus.MemRead && !bus.MemValid) ? wait_cnt + 1 : 0;

  // Data Register model and event logs, sampled mid-cycle.
  logic [31:0] dr = '0;
  logic [7:0]  funsel_log = '0;
  logic [7:0]  addr_log = '0;
  int dre_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge Clock) begin
    if (bus.DR_E) begin
      case (bus.DR_FunSel)
        2'b00:   dr = {24'h0, bus.DR_I};
        2'b01:   dr = {{24{bus.DR_I[7]}}, bus.DR_I};
        2'b10:   dr = {dr[23:0], bus.DR_I};
        default: dr = 32'hDEADBEEF;
      endcase
      dre_cnt++;
      funsel_log = {funsel_log[5:0], bus.DR_FunSel};
    end
    if (bus.MemRead && bus.MemValid) addr_log = {addr_log[5:0], bus.AddrOffset};
    if (bus.Done)  done_cnt++;
    if (bus.Error) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, bus.MemRead, bus.AddrOffset, bus.DR_I, bus.DR_E,
            bus.DR_FunSel, bus.Busy, bus.Done, bus.Error};
  endfunction

  int done_cyc, err_cyc, busy_cnt;
  int b_dre, b_done, b_err;

  task automatic snap();
    b_dre  = dre_cnt;
    b_done = done_cnt;
    b_err  = err_cnt;
  endtask

  // Issues one Start and follows the load until Busy drops (bounded).
  task automatic run_load(input logic [1:0] sz, input logic se, input int dly);
    mem_delay = dly;
    snap();
    @(posedge Clock); #1;
    bus.Start = 1'b1; bus.Size = sz; bus.SignExt = se;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    done_cyc = 0; err_cyc = 0; busy_cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge Clock);
      if (bus.Busy)  busy_cnt++;
      if (bus.Done)  done_cyc = n;
      if (bus.Error) err_cyc = n;
      if (!bus.Busy) break;
    end
  endtask

  bit found;

  initial begin
    Reset = 1'b1;
    bus.Start = 1'b0; bus.Size = '0; bus.SignExt = 1'b0; bus.Abort = 1'b0;
    mem_b[0] = 8'h12; mem_b[1] = 8'h34; mem_b[2] = 8'h56; mem_b[3] = 8'h78;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    chk("reset_outputs", outs(), 32'h0);

    // 4-byte zero-extended, zero-wait memory
    run_load(2'b11, 1'b0, 0);
    chk("t1_dr", dr, 32'h12345678);
    chk("t1_done_cycle", done_cyc, 9);
    chk("t1_done_count", done_cnt - b_done, 1);
    chk("t1_addr_seq", {24'h0, addr_log}, 32'h1B);
    chk("t1_funsel_seq", {24'h0, funsel_log}, 32'h2A);
    chk("t1_dre_count", dre_cnt - b_dre, 4);
    chk("t1_busy_cycles", busy_cnt, 9);

    // 2-byte sign-extended
    mem_b[0] = 8'h80; mem_b[1] = 8'h25;
    run_load(2'b01, 1'b1, 0);
    chk("t2_dr", dr, 32'hFFFF8025);
    chk("t2_funsel_seq", {28'h0, funsel_log[3:0]}, 32'h6);
    chk("t2_done_cycle", done_cyc, 5);

    // 1 byte, MemValid delayed 3 cycles
    mem_b[0] = 8'h25;
    run_load(2'b00, 1'b0, 3);
    chk("t3_dr", dr, 32'h00000025);
    chk("t3_dre_count", dre_cnt - b_dre, 1);
    chk("t3_busy_cycles", busy_cnt, 6);
    chk("t3_done_cycle", done_cyc, 6);

    // Timeout: memory never answers
    mem_en = 1'b0;
    run_load(2'b11, 1'b0, 0);
    chk("t4_error_cycle", err_cyc, 16);
    chk("t4_error_count", err_cnt - b_err, 1);
    chk("t4_dre_count", dre_cnt - b_dre, 0);
    chk("t4_done_count", done_cnt - b_done, 0);
    chk("t4_busy_cycles", busy_cnt, 16);
    chk("t4_idle_after", {31'h0, bus.Busy}, 32'h0);
    mem_en = 1'b1;

    // Abort together with MemValid on byte 1 of a 4-byte load
    mem_b[0] = 8'h12; mem_b[1] = 8'h34; mem_b[2] = 8'h56; mem_b[3] = 8'h78;
    mem_delay = 0;
    snap();
    @(posedge Clock); #1;
    bus.Start = 1'b1; bus.Size = 2'b11; bus.SignExt = 1'b0;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clock);
      if (bus.MemRead && bus.AddrOffset == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_reached_byte1", {31'h0, found}, 32'h1);
    bus.Abort = 1'b1;
    @(posedge Clock); #1;
    bus.Abort = 1'b0;
    chk("t5_busy_after_abort", {31'h0, bus.Busy}, 32'h0);
    chk("t5_dr_i_kept", {24'h0, bus.DR_I}, 32'h12);
    repeat (10) @(negedge Clock);
    chk("t5_dre_count", dre_cnt - b_dre, 1);
    chk("t5_no_done", done_cnt - b_done, 0);
    chk("t5_no_error", err_cnt - b_err, 0);

    // Reset in WRITE
    @(posedge Clock); #1;
    bus.Start = 1'b1; bus.Size = 2'b11;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clock);
      if (bus.DR_E) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_reached_write", {31'h0, found}, 32'h1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("t6_outputs_after_reset", outs(), 32'h0);

    // Start while busy is neither honoured nor queued
    snap();
    mem_delay = 3;
    @(posedge Clock); #1;
    bus.Start = 1'b1; bus.Size = 2'b01; bus.SignExt = 1'b0;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    @(posedge Clock); #1;
    bus.Start = 1'b1; bus.Size = 2'b11;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    repeat (25) @(negedge Clock);
    chk("t7_done_count", done_cnt - b_done, 1);
    chk("t7_dre_count", dre_cnt - b_dre, 2);
    chk("t7_idle", {31'h0, bus.Busy}, 32'h0);
    chk("t7_dr", dr, 32'h00001234);

    // Reset beats a simultaneous Start
    @(posedge Clock); #1;
    Reset = 1'b1; bus.Start = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0; bus.Start = 1'b0;
    chk("t8_reset_over_start", {31'h0, bus.Busy}, 32'h0);
    @(negedge Clock);
    chk("t8_still_idle", {31'h0, bus.Busy}, 32'h0);

    // MemValid while idle is ignored
    snap();
    force_valid = 1'b1;
    repeat (3) @(negedge Clock);
    chk("t9_idle_valid_busy", {31'h0, bus.Busy}, 32'h0);
    chk("t9_idle_valid_dr_i", {24'h0, bus.DR_I}, 32'h0);
    chk("t9_idle_valid_dre", dre_cnt - b_dre, 0);
    force_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
